bram_dp_init: RTL and testbench
===============================

Name: bram_dp_init

Overview:
- Parametrised successor to the single-port behavioural FIR tap/data BRAM.
- Generalised in data width and depth; adds a second read-only port, an optional output register stage, and a post-reset hardware clear sequence.
- Sits beside the FIR engine:
  - Port A serves AXI-Lite tap writes and readback.
  - Port B serves the MAC datapath reads.
- Byte-addressed like the existing BRAM, so firmware address maps carry over unchanged.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8; NB_COL = DATA_WIDTH/8.
- DEPTH, 11, number of words.
- ADDR_WIDTH, 12, byte-address width for both ports.
- OUT_REG, 0. 0 = read latency 1 cycle; 1 = read latency 2 cycles (extra output register).

Ports:
- CLK  in  1  single clock, all logic rising-edge.
- RST_N  in  1  asynchronous, active-low reset.
- EN_A  in  1  port A enable.
- WE_A  in  NB_COL  port A byte write enables; bit i writes Di_A[8i+7:8i].
- A_A  in  ADDR_WIDTH  port A byte address.
- Di_A  in  DATA_WIDTH  port A write data.
- Do_A  out  DATA_WIDTH  port A read data.
- VALID_A  out  1  Do_A valid strobe.
- EN_B  in  1  port B read enable.
- A_B  in  ADDR_WIDTH  port B byte address.
- Do_B  out  DATA_WIDTH  port B read data.
- VALID_B  out  1  Do_B valid strobe.
- INIT_BUSY  out  1  high while the clear sequence runs.
- ADDR_ERR  out  1  sticky out-of-range access flag.

Behaviour:
- Clock and reset: one clock, CLK; reset RST_N is asynchronous and active-low.
- Reset values: Do_A = Do_B = 0, VALID_A = VALID_B = 0, ADDR_ERR = 0, INIT_BUSY = 1, FSM = INIT, clear counter = 0. Memory contents are not reset directly; the clear sequence zeroes them.
- Word index: A >> log2(NB_COL); low byte-offset bits are ignored.
- FSM INIT:
  - Writes word[cnt] = 0 each cycle; cnt increments 0..DEPTH-1.
  - At cnt == DEPTH-1, transitions to READY on the next edge.
  - INIT_BUSY = 1 for exactly DEPTH cycles after reset release.
- FSM READY: INIT_BUSY = 0; normal operation; the FSM never leaves READY except via reset.
- RST_N asserted mid-INIT or mid-operation: everything returns to reset values and the clear restarts from word 0.
- During INIT: EN_A and EN_B are ignored. No writes, VALID_x stay 0, ADDR_ERR is not updated.
- Port A write: when EN_A = 1 and WE_A != 0 in READY, the enabled bytes are written at the edge; the other bytes are preserved.
- Port A read:
  - Issued when EN_A = 1 in READY, with any WE_A value.
  - Read-first: a same-cycle write to the same word returns the old data.
- Port B read: issued when EN_B = 1 in READY.
- Latency:
  - OUT_REG = 0: Do_x and VALID_x are updated 1 edge after the request.
  - OUT_REG = 1: updated 2 edges after the request.
  - VALID_x is a 1-cycle pulse per request.
  - Back-to-back requests give one result per cycle in order.
  - Do_x holds its last value when no result is delivered.
- Out-of-range (word index >= DEPTH):
  - Writes are dropped.
  - Reads return 0 with VALID_x = 1.
  - ADDR_ERR is set on the following edge and stays set until reset.
- Port collision: port B reading the word port A writes in the same cycle returns the old data (feature disabled).
- Both ports reading the same word simultaneously is legal; both get identical data.

Optional Feature:
- Macro: BRAM_DP_WR_FWD_EN.
- Defined: on a port B read colliding with a same-cycle port A write to the same word, Do_B returns the byte-merged new data. Enabled bytes come from Di_A; the remaining bytes come from the stored word. Latency is unchanged. Port A stays read-first.
- Undefined: Do_B returns the pre-write contents. No forwarding logic is instantiated.

Test Plan:
1. Release RST_N, DEPTH = 11 -> INIT_BUSY high for exactly 11 cycles, then low; port B reads of words 0..10 all return 0x00000000 with VALID_B one cycle later (OUT_REG = 0).
2. Write 0xAABBCCDD at A_A = 0x008 with WE_A = 4'hF, then WE_A = 4'b0101 with Di_A = 0x11223344 -> read returns 0xAA22CC44; with OUT_REG = 1, VALID_B arrives 2 cycles after EN_B.
3. Port A write 0x12345678 to A_A = 0x00C while port B reads A_B = 0x00C, word previously 0x0 -> Do_B = 0x0 without the macro, 0x12345678 with BRAM_DP_WR_FWD_EN; Do_A (same-cycle read) = 0x0 in both builds.
4. Write to A_A = 0x02C (word 11) -> no memory change, ADDR_ERR = 1 next edge and stays set; subsequent read at 0x02C returns 0 with VALID_A = 1.
5. Assert RST_N low at INIT cycle 5 and release -> INIT_BUSY stays high for a fresh 11 cycles; EN_B pulses during INIT produce no VALID_B.
6. Streaming port B reads of words 0,1,2,3 on consecutive cycles -> four consecutive VALID_B pulses, data in issue order.

Source files
------------

// File: rtl/bram_dp_init.sv
// Dual-port byte-addressed BRAM: port A read/write, port B read-only, post-reset clear.
// Optional macro BRAM_DP_WR_FWD_EN forwards a same-cycle port A write to a colliding port B read.
module bram_dp_init #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 11,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    EN_A,
  input  logic [DATA_WIDTH/8-1:0] WE_A,
  input  logic [ADDR_WIDTH-1:0]   A_A,
  input  logic [DATA_WIDTH-1:0]   Di_A,
  output logic [DATA_WIDTH-1:0]   Do_A,
  output logic                    VALID_A,
  input  logic                    EN_B,
  input  logic [ADDR_WIDTH-1:0]   A_B,
  output logic [DATA_WIDTH-1:0]   Do_B,
  output logic                    VALID_B,
  output logic                    INIT_BUSY,
  output logic                    ADDR_ERR
);

  localparam int unsigned NB_COL = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(NB_COL);
  localparam int unsigned IDX_W  = ADDR_WIDTH - OFF_W;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e              state_q;
  logic [MEM_AW-1:0]   cnt_q;
  logic                busy_q;
  logic                err_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  vld_a_s1_q, vld_b_s1_q;
  logic [DATA_WIDTH-1:0] dat_a_s1_q, dat_b_s1_q;
  logic [DATA_WIDTH-1:0] rd_a_d, rd_b_d;

  logic [IDX_W-1:0]  idx_a, idx_b;
  logic [MEM_AW-1:0] maddr_a, maddr_b;
  logic              ready, inr_a, inr_b, req_a, req_b, wr_a;

  // Request decode: byte offset dropped, range checked against DEPTH
  assign idx_a   = A_A[ADDR_WIDTH-1:OFF_W];
  assign idx_b   = A_B[ADDR_WIDTH-1:OFF_W];
  assign maddr_a = MEM_AW'(idx_a);
  assign maddr_b = MEM_AW'(idx_b);
  assign inr_a   = (32'(idx_a) < DEPTH);
  assign inr_b   = (32'(idx_b) < DEPTH);
  assign ready   = (state_q == S_READY);
  assign req_a   = EN_A & ready;
  assign req_b   = EN_B & ready;
  assign wr_a    = req_a & (|WE_A) & inr_a;

  // Clear sequencer: walks every word once after reset, then parks in READY
  always_ff @(posedge CLK or negedge RST_N) begin : p_fsm
    if (!RST_N) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (state_q == S_INIT) begin
      if (cnt_q == MEM_AW'(DEPTH - 1)) begin
        state_q <= S_READY;
        busy_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_q + MEM_AW'(1);
      end
    end
  end

  // Storage array; the clear sequence owns the write port until READY
  always_ff @(posedge CLK) begin : p_mem
    if (state_q == S_INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_a) begin
      for (int unsigned i = 0; i < NB_COL; i++) begin
        if (WE_A[i]) mem_q[maddr_a][8*i +: 8] <= Di_A[8*i +: 8];
      end
    end
  end

  // Read muxes: out-of-range reads return zero
  always_comb begin : p_rd
    rd_a_d = '0;
    rd_b_d = '0;
    if (inr_a) rd_a_d = mem_q[maddr_a];
    if (inr_b) begin
      rd_b_d = mem_q[maddr_b];
`ifdef BRAM_DP_WR_FWD_EN
      if (wr_a && (maddr_a == maddr_b)) begin
        for (int unsigned i = 0; i < NB_COL; i++) begin
          if (WE_A[i]) rd_b_d[8*i +: 8] = Di_A[8*i +: 8];
        end
      end
`endif
    end
  end

  // First read stage; data holds when no request is captured
  always_ff @(posedge CLK or negedge RST_N) begin : p_rd_s1
    if (!RST_N) begin
      vld_a_s1_q <= 1'b0;
      vld_b_s1_q <= 1'b0;
      dat_a_s1_q <= '0;
      dat_b_s1_q <= '0;
      err_q      <= 1'b0;
    end else begin
      vld_a_s1_q <= req_a;
      vld_b_s1_q <= req_b;
      if (req_a) dat_a_s1_q <= rd_a_d;
      if (req_b) dat_b_s1_q <= rd_b_d;
      err_q <= err_q | (req_a & ~inr_a) | (req_b & ~inr_b);
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  vld_a_o_q, vld_b_o_q;
      logic [DATA_WIDTH-1:0] dat_a_o_q, dat_b_o_q;

      always_ff @(posedge CLK or negedge RST_N) begin : p_out
        if (!RST_N) begin
          vld_a_o_q <= 1'b0;
          vld_b_o_q <= 1'b0;
          dat_a_o_q <= '0;
          dat_b_o_q <= '0;
        end else begin
          vld_a_o_q <= vld_a_s1_q;
          vld_b_o_q <= vld_b_s1_q;
          if (vld_a_s1_q) dat_a_o_q <= dat_a_s1_q;
          if (vld_b_s1_q) dat_b_o_q <= dat_b_s1_q;
        end
      end

      assign Do_A    = dat_a_o_q;
      assign Do_B    = dat_b_o_q;
      assign VALID_A = vld_a_o_q;
      assign VALID_B = vld_b_o_q;
    end else begin : g_noreg
      assign Do_A    = dat_a_s1_q;
      assign Do_B    = dat_b_s1_q;
      assign VALID_A = vld_a_s1_q;
      assign VALID_B = vld_b_s1_q;
    end
  endgenerate

  assign INIT_BUSY = busy_q;
  assign ADDR_ERR  = err_q;

endmodule

// File: tb/tb_bram_dp_init.sv
// Directed self-checking bench for bram_dp_init (default parameters).
module tb_bram_dp_init;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 11;
  localparam int unsigned AW    = 12;
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned OREG  = 0;
  localparam int          LAT   = int'(OREG) + 1;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          EN_A, EN_B;
  logic [NB-1:0] WE_A;
  logic [AW-1:0] A_A, A_B;
  logic [DW-1:0] Di_A, Do_A, Do_B;
  logic          VALID_A, VALID_B, INIT_BUSY, ADDR_ERR;

  int n_run  = 0;
  int n_fail = 0;

  bram_dp_init #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .OUT_REG(OREG)
  ) u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .EN_A(EN_A), .WE_A(WE_A), .A_A(A_A), .Di_A(Di_A), .Do_A(Do_A), .VALID_A(VALID_A),
    .EN_B(EN_B), .A_B(A_B), .Do_B(Do_B), .VALID_B(VALID_B),
    .INIT_BUSY(INIT_BUSY), .ADDR_ERR(ADDR_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    EN_A = 1'b0;
    WE_A = '0;
    EN_B = 1'b0;
  endtask

  task automatic wr_a(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [NB-1:0] we);
    EN_A = 1'b1; WE_A = we; A_A = addr; Di_A = data;
    tick();
    idle();
    repeat (LAT - 1) tick();
  endtask

  task automatic rd_a(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    EN_A = 1'b1; WE_A = '0; A_A = addr;
    tick();
    idle();
    repeat (LAT - 1) tick();
    check({tag, "_v"}, DW'(VALID_A), DW'(1));
    check(tag, Do_A, exp);
  endtask

  task automatic rd_b(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    EN_B = 1'b1; A_B = addr;
    tick();
    idle();
    repeat (LAT - 1) tick();
    check({tag, "_v"}, DW'(VALID_B), DW'(1));
    check(tag, Do_B, exp);
  endtask

  // Same-cycle port A write and port B read of one address
  task automatic collide(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [NB-1:0] we, output logic [DW-1:0] da,
                         output logic [DW-1:0] db, output logic vb);
    EN_A = 1'b1; WE_A = we; A_A = addr; Di_A = data;
    EN_B = 1'b1; A_B = addr;
    tick();
    idle();
    repeat (LAT - 1) tick();
    da = Do_A; db = Do_B; vb = VALID_B;
  endtask

  // Drive both ports hard during the clear; count busy cycles and stray valids
  task automatic run_init(output int n, output int nv);
    n = 0; nv = 0;
    EN_A = 1'b1; WE_A = '1; A_A = '0; Di_A = '1;
    EN_B = 1'b1; A_B = '0;
    while (INIT_BUSY === 1'b1 && n < 40) begin
      tick();
      n++;
      if (VALID_A === 1'b1 || VALID_B === 1'b1) nv++;
    end
    idle();
  endtask

  initial begin
    int n, nv;
    logic [DW-1:0] da, db;
    logic          vb;
    logic [DW-1:0] exp_full, exp_part;

`ifdef BRAM_DP_WR_FWD_EN
    exp_full = 32'h1234_5678;
    exp_part = 32'hAABB_3344;
`else
    exp_full = 32'h0000_0000;
    exp_part = 32'hAABB_CCDD;
`endif

    idle();
    A_A = '0; A_B = '0; Di_A = '0;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", DW'(INIT_BUSY), DW'(1));
    check("rst_do_a", Do_A, '0);
    check("rst_do_b", Do_B, '0);
    check("rst_vld", DW'({VALID_A, VALID_B}), '0);
    check("rst_err", DW'(ADDR_ERR), '0);

    RST_N = 1'b1;
    run_init(n, nv);
    check("init_len", DW'(n), DW'(DEPTH));
    check("init_vld", DW'(nv), '0);
    check("init_err", DW'(ADDR_ERR), '0);
    for (int i = 0; i < int'(DEPTH); i++) rd_b("clr_b", AW'(4 * i), '0);
    tick();
    check("pulse_b", DW'(VALID_B), '0);

    wr_a(12'h008, 32'hAABB_CCDD, 4'hF);
    wr_a(12'h008, 32'h1122_3344, 4'b0101);
    rd_a("bytes_a", 12'h008, 32'hAA22_CC44);
    rd_b("bytes_b", 12'h00A, 32'hAA22_CC44);

    collide(12'h00C, 32'h1234_5678, 4'hF, da, db, vb);
    check("coll_a", da, '0);
    check("coll_b", db, exp_full);
    check("coll_v", DW'(vb), DW'(1));
    rd_a("coll_wr", 12'h00C, 32'h1234_5678);

    wr_a(12'h010, 32'hAABB_CCDD, 4'hF);
    collide(12'h010, 32'h1122_3344, 4'b0011, da, db, vb);
    check("pcoll_a", da, 32'hAABB_CCDD);
    check("pcoll_b", db, exp_part);
    rd_b("pcoll_wr", 12'h010, 32'hAABB_3344);

    check("err_pre", DW'(ADDR_ERR), '0);
    EN_A = 1'b1; WE_A = 4'hF; A_A = 12'h02C; Di_A = 32'hFFFF_FFFF;
    tick();
    idle();
    check("err_set", DW'(ADDR_ERR), DW'(1));
    repeat (LAT - 1) tick();
    rd_b("oor_w10", 12'h028, '0);
    rd_a("oor_prev", 12'h008, 32'hAA22_CC44);
    rd_a("oor_rd_a", 12'h02C, '0);
    rd_b("oor_rd_b", 12'h010, 32'hAABB_3344);
    rd_b("oor_rd_b2", 12'hFFC, '0);
    repeat (3) tick();
    check("err_hold", DW'(ADDR_ERR), DW'(1));

    for (int i = 0; i < 4; i++) wr_a(AW'(4 * i), 32'hC0DE_0000 + DW'(i), 4'hF);
    for (int i = 0; i < 4 + LAT - 1; i++) begin
      if (i < 4) begin
        EN_B = 1'b1; A_B = AW'(4 * i);
      end else begin
        EN_B = 1'b0;
      end
      tick();
      if (i >= LAT - 1) begin
        check("strm_v", DW'(VALID_B), DW'(1));
        check("strm_d", Do_B, 32'hC0DE_0000 + DW'(i - (LAT - 1)));
      end
    end
    idle();
    tick();
    check("strm_end", DW'(VALID_B), '0);
    check("strm_hold", Do_B, 32'hC0DE_0003);

    wr_a(12'h024, 32'hDEAD_BEEF, 4'hF);
    rd_a("w9_pre", 12'h024, 32'hDEAD_BEEF);
    RST_N = 1'b0;
    tick();
    check("rst2_err", DW'(ADDR_ERR), '0);
    check("rst2_busy", DW'(INIT_BUSY), DW'(1));
    check("rst2_do_b", Do_B, '0);
    RST_N = 1'b1;
    EN_B = 1'b1; A_B = '0;
    repeat (5) tick();
    check("mid_busy", DW'(INIT_BUSY), DW'(1));
    check("mid_vld", DW'(VALID_B), '0);
    idle();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    run_init(n, nv);
    check("reinit_len", DW'(n), DW'(DEPTH));
    check("reinit_vld", DW'(nv), '0);
    rd_b("reinit_w9", 12'h024, '0);
    rd_b("reinit_w2", 12'h008, '0);
    rd_a("reinit_w0", 12'h000, '0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
